// File: rtl/melody_pkg.sv
// melody_pkg: shared state enum, ROM word layout and duration decode for the melody sequencer
package melody_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_t;
  localparam logic [1:0] DUR_1 = 2'b00;
  localparam logic [1:0] DUR_2 = 2'b01;
  localparam logic [1:0] DUR_4 = 2'b10;
  localparam logic [1:0] END_CODE = 2'b11;
  localparam int HP_LSB = 0;
  localparam int HP_MSB = 17;
  localparam int DUR_LSB = 18;
  localparam int DUR_MSB = 19;
  function automatic logic [2:0] dur_beats(input logic [1:0] code);
    return code == DUR_1 ? 3'd1 : code == DUR_2 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: square wave whose half-period is half_period+1 enabled cycles
// Ports: clk, rst_n (async active-low), en (advance phase), clr (zero phase, sq=0),
//        half_period (wrap value of the phase counter), sq (square-wave output)
module tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [17:0] half_period,
  output logic        sq
);
  logic [17:0] r_cnt;
  logic        r_sq;
  logic        w_wrap;
  assign w_wrap = r_cnt == half_period;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 18'd1;
      r_sq  <= w_wrap ? ~r_sq : r_sq;
    end
  assign sq = r_sq;
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a note ROM, times notes in beats and drives a square-wave sample
// Ports: CLOCK_50/resetn (async active-low); start/stop pulses; pause level; loop_en;
//        rom_addr/rom_q note ROM (1-cycle read); half_period, tone_en, sample (signed 32-bit);
//        playing, beat_pulse, done status
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BEAT_CYCLES = 9_500_000,
  parameter int LAST_ADDR   = 140,
  parameter int GAP_CYCLES  = 250_000,
  parameter int AMPLITUDE   = 10_000_000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [19:0]       rom_q,
  output logic [17:0]       half_period,
  output logic              tone_en,
  output logic [31:0]       sample,
  output logic              playing,
  output logic              beat_pulse,
  output logic              done
);
  localparam int BW = $clog2(BEAT_CYCLES);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [BW-1:0] GAP_START = BW'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [31:0] AMP_P = 32'(AMPLITUDE);
  localparam logic [31:0] AMP_N = 32'(-AMPLITUDE);
  state_t            r_state;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [17:0]       r_half_period;
  logic [2:0]        r_beats_left;
  logic [BW-1:0]     r_beat_cnt;
  logic              r_done;
  logic              w_play, w_beat_end, w_last_beat, w_tone_en, w_song_end, w_sq;
  assign w_play      = r_state == S_PLAY;
  assign w_beat_end  = w_play && !pause && r_beat_cnt == BEAT_LAST;
  assign w_last_beat = r_beats_left == 3'd1;
  // the tail of the final beat is silenced so consecutive notes are articulated
  assign w_tone_en   = w_play && r_half_period != '0 && !pause &&
                       !(w_last_beat && r_beat_cnt >= GAP_START);
  // song ends either on an end-marker word or after the last playable note
  assign w_song_end  = (r_state == S_LOAD && rom_q[DUR_MSB:DUR_LSB] == END_CODE) ||
                       (w_beat_end && w_last_beat && r_rom_addr == ADDR_W'(LAST_ADDR));
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_rom_addr    <= '0;
      r_half_period <= '0;
      r_beats_left  <= '0;
      r_beat_cnt    <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && r_state != S_IDLE) r_state <= S_IDLE;
      else if (start) begin
        r_state    <= S_FETCH;
        r_rom_addr <= '0;
      end else if (w_song_end) begin
        r_state    <= loop_en ? S_FETCH : S_IDLE;
        r_rom_addr <= loop_en ? '0 : r_rom_addr;
        r_done     <= !loop_en;
      end else
        case (r_state)
          S_FETCH: r_state <= S_LOAD;
          S_LOAD: begin
            r_half_period <= rom_q[HP_MSB:HP_LSB];
            r_beats_left  <= dur_beats(rom_q[DUR_MSB:DUR_LSB]);
            r_beat_cnt    <= '0;
            r_state       <= S_PLAY;
          end
          S_PLAY:
            if (w_beat_end) begin
              r_beat_cnt   <= '0;
              r_beats_left <= r_beats_left - 3'd1;
              if (w_last_beat) begin
                r_rom_addr <= r_rom_addr + ADDR_W'(1);
                r_state    <= S_FETCH;
              end
            end else if (!pause) r_beat_cnt <= r_beat_cnt + BW'(1);
          default: ;
        endcase
    end
  tone_gen u_tone (
    .clk        (CLOCK_50),
    .rst_n      (resetn),
    .en         (w_tone_en),
    .clr        (r_state == S_LOAD),
    .half_period(r_half_period),
    .sq         (w_sq)
  );
  assign rom_addr    = r_rom_addr;
  assign half_period = r_half_period;
  assign tone_en     = w_tone_en;
  assign sample      = w_tone_en ? (w_sq ? AMP_P : AMP_N) : '0;
  assign playing     = r_state != S_IDLE;
  assign beat_pulse  = w_beat_end;
  assign done        = r_done;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: scoreboard bench; stimulus queues cycle-tagged expectations, a monitor checks them
module tb_melody_sequencer;
  localparam logic [31:0] PA = 32'd10_000_000;
  localparam logic [31:0] NA = -PA;
  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [9:0]  rom_addr;
  logic [19:0] rom_q;
  logic [17:0] half_period;
  logic        tone_en, playing, beat_pulse, done;
  logic [31:0] sample;
  logic [19:0] rom [0:15];
  int          cyc = 0, n_tests = 0, n_fail = 0;
  typedef struct {int c; int s; logic [31:0] v;} exp_t;
  exp_t q[$];
  string nm[7] = '{"rom_addr", "playing", "tone_en", "sample", "done", "beat_pulse", "half_period"};

  melody_sequencer #(.ADDR_W(10), .BEAT_CYCLES(20), .LAST_ADDR(3), .GAP_CYCLES(4), .AMPLITUDE(10_000_000)) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_q(rom_q), .half_period(half_period), .tone_en(tone_en),
    .sample(sample), .playing(playing), .beat_pulse(beat_pulse), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rom_q <= rom[rom_addr[3:0]];
  end

  function automatic logic [31:0] obs(input int s);
    case (s)
      0: return 32'(rom_addr);
      1: return 32'(playing);
      2: return 32'(tone_en);
      3: return sample;
      4: return 32'(done);
      5: return 32'(beat_pulse);
      default: return 32'(half_period);
    endcase
  endfunction

  always @(negedge clk)
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (e.c < cyc || obs(e.s) !== e.v) begin
        n_fail++;
        $display("FAIL %s @cycle %0d: got %0d expected %0d", nm[e.s], e.c, $signed(obs(e.s)), $signed(e.v));
      end
    end

  task automatic ex(input int c, input int s, input logic [31:0] v);
    exp_t e;
    int   i;
    e = '{c, s, v};
    i = q.size();
    while (i > 0 && q[i-1].c > c) i--;
    q.insert(i, e);
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic s_start, input logic s_stop);
    start = s_start;
    stop  = s_stop;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic fetch_ex(input int c, input int a);
    ex(c, 0, 32'(a));
    for (int k = 0; k < 2; k++) begin
      ex(c + k, 1, 32'd1);
      ex(c + k, 2, 32'd0);
      ex(c + k, 3, 32'd0);
      ex(c + k, 4, 32'd0);
      ex(c + k, 5, 32'd0);
    end
  endtask

  task automatic note_ex(input int p, input int hp, input int nb);
    logic on;
    ex(p, 6, 32'(hp));
    for (int i = 0; i < nb * 20; i++) begin
      on = hp != 0 && !(i >= (nb - 1) * 20 + 16);
      ex(p + i, 2, 32'(on));
      ex(p + i, 3, on ? (((i / (hp + 1)) % 2) != 0 ? PA : NA) : 32'd0);
      ex(p + i, 5, 32'(i % 20 == 19));
      ex(p + i, 1, 32'd1);
      ex(p + i, 4, 32'd0);
    end
  endtask

  task automatic four_notes(input int t);
    fetch_ex(t + 1, 0);
    note_ex(t + 3, 3, 2);
    fetch_ex(t + 43, 1);
    note_ex(t + 45, 0, 1);
    fetch_ex(t + 65, 2);
    note_ex(t + 67, 2, 1);
    fetch_ex(t + 87, 3);
    note_ex(t + 89, 1, 1);
  endtask

  initial begin
    int t, s;
    foreach (rom[i]) rom[i] = '0;
    rom[0] = {2'b01, 18'd3};
    rom[1] = {2'b00, 18'd0};
    rom[2] = {2'b11, 18'd0};
    rom[3] = {2'b00, 18'd1};
    for (int k = 0; k < 7; k++) ex(1, k, 32'd0);
    go(3);
    resetn = 1'b1;
    go(5);
    // single 2-beat note, a rest, then end marker
    t = cyc;
    fetch_ex(t + 1, 0);
    note_ex(t + 3, 3, 2);
    fetch_ex(t + 43, 1);
    note_ex(t + 45, 0, 1);
    fetch_ex(t + 65, 2);
    ex(t + 67, 4, 32'd1);
    ex(t + 67, 1, 32'd0);
    ex(t + 67, 0, 32'd2);
    ex(t + 68, 4, 32'd0);
    ex(t + 68, 2, 32'd0);
    strobe(1'b1, 1'b0);
    go(t + 70);
    // song ends after LAST_ADDR without loop
    rom[2] = {2'b00, 18'd2};
    t = cyc;
    four_notes(t);
    ex(t + 109, 4, 32'd1);
    ex(t + 109, 1, 32'd0);
    ex(t + 109, 0, 32'd3);
    ex(t + 110, 4, 32'd0);
    strobe(1'b1, 1'b0);
    go(t + 112);
    // LAST_ADDR wraps to 0 with loop_en, then stop
    loop_en = 1'b1;
    t = cyc;
    four_notes(t);
    fetch_ex(t + 109, 0);
    ex(t + 111, 6, 32'd3);
    ex(t + 111, 2, 32'd1);
    ex(t + 111, 3, NA);
    strobe(1'b1, 1'b0);
    go(t + 115);
    s = cyc;
    ex(s + 1, 1, 32'd0);
    ex(s + 1, 2, 32'd0);
    ex(s + 1, 3, 32'd0);
    ex(s + 1, 4, 32'd0);
    ex(s + 2, 4, 32'd0);
    strobe(1'b0, 1'b1);
    loop_en = 1'b0;
    go(s + 4);
    // pause for 10 cycles mid-note
    rom[2] = {2'b11, 18'd0};
    t = cyc;
    fetch_ex(t + 1, 0);
    for (int i = 0; i < 5; i++) ex(t + 3 + i, 3, i < 4 ? NA : PA);
    for (int c = t + 8; c < t + 18; c++) begin
      ex(c, 3, 32'd0);
      ex(c, 2, 32'd0);
      ex(c, 5, 32'd0);
    end
    for (int c = t + 18; c < t + 49; c++) begin
      ex(c, 3, (((c - t - 13) / 4) % 2) != 0 ? PA : NA);
      ex(c, 2, 32'd1);
    end
    for (int c = t + 49; c < t + 53; c++) begin
      ex(c, 3, 32'd0);
      ex(c, 2, 32'd0);
    end
    ex(t + 22, 5, 32'd0);
    ex(t + 32, 5, 32'd1);
    ex(t + 43, 0, 32'd0);
    ex(t + 43, 1, 32'd1);
    fetch_ex(t + 53, 1);
    ex(t + 77, 4, 32'd1);
    ex(t + 77, 1, 32'd0);
    strobe(1'b1, 1'b0);
    go(t + 8);
    pause = 1'b1;
    go(t + 18);
    pause = 1'b0;
    go(t + 80);
    // asynchronous reset mid-PLAY
    t = cyc;
    for (int k = 0; k < 7; k++) ex(t + 10, k, 32'd0);
    for (int c = t + 11; c < t + 14; c++) ex(c, 4, 32'd0);
    ex(t + 11, 1, 32'd0);
    ex(t + 9, 6, 32'd3);
    ex(t + 9, 1, 32'd1);
    strobe(1'b1, 1'b0);
    go(t + 10);
    resetn = 1'b0;
    go(t + 13);
    resetn = 1'b1;
    go(t + 15);
    // start and stop together: stop wins, then start restarts from 0
    t = cyc;
    fetch_ex(t + 1, 0);
    ex(t + 50, 1, 32'd1);
    ex(t + 50, 0, 32'd1);
    ex(t + 51, 1, 32'd0);
    ex(t + 51, 2, 32'd0);
    ex(t + 51, 3, 32'd0);
    ex(t + 51, 4, 32'd0);
    ex(t + 51, 0, 32'd1);
    fetch_ex(t + 56, 0);
    ex(t + 58, 6, 32'd3);
    ex(t + 58, 2, 32'd1);
    ex(t + 58, 3, NA);
    ex(t + 61, 1, 32'd0);
    strobe(1'b1, 1'b0);
    go(t + 50);
    strobe(1'b1, 1'b1);
    go(t + 55);
    strobe(1'b1, 1'b0);
    go(t + 60);
    strobe(1'b0, 1'b1);
    go(t + 63);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL leftover: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Controller that plays a stored melody through the audio path. It walks a synchronous note ROM, times each note in beats, and runs a square-wave tone generator whose half-period comes from the ROM word. It produces the 32-bit signed sample that is summed into the left and right channel outputs ahead of the Audio_Controller. It replaces the free-running address counter and toggle logic in the top level with a proper start/stop/pause sequencer that also handles end-of-song.

## Interface
- ADDR_W, 10: note ROM address width
- BEAT_CYCLES, 9_500_000: CLOCK_50 cycles per beat
- LAST_ADDR, 140: highest playable ROM address; the song ends after this note
- GAP_CYCLES, 250_000: silent articulation tail at the end of each note (must be < BEAT_CYCLES)
- AMPLITUDE, 10_000_000: square-wave magnitude
- CLOCK_50  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; (re)start playback at address 0
- stop  in  1  one-cycle pulse; abort playback and return to IDLE
- pause  in  1  level; freezes note timing and mutes output while high
- loop_en  in  1  at end of song, restart from address 0 instead of finishing
- rom_addr  out  ADDR_W  note ROM address; ROM read latency is 1 cycle
- rom_q  in  20  ROM word: [17:0] half-period in cycles (0 = rest); [19:18] duration code: 00 = 1 beat, 01 = 2, 10 = 4, 11 = end marker
- half_period  out  18  latched half-period of the current note
- tone_en  out  1  tone audible this cycle
- sample  out  32  tone_en ? (sq ? +AMPLITUDE : −AMPLITUDE) : 0, two's complement
- playing  out  1  high in FETCH, LOAD, or PLAY
- beat_pulse  out  1  one cycle at each beat boundary while in PLAY
- done  out  1  one-cycle pulse when the song finishes (not when it loops)

## Operation
- States:
  - IDLE: entered on reset. start → FETCH with rom_addr = 0.
  - FETCH: one cycle; the address is presented to the ROM. → LOAD.
  - LOAD: capture rom_q.
    - If the code is 11: go to end handling.
    - Otherwise latch half_period, set beats_left = 1/2/4, clear beat_cnt, clear tone phase and sq = 0. → PLAY.
  - PLAY: while pause = 0, beat_cnt increments. At beat_cnt = BEAT_CYCLES−1, beat_cnt wraps to 0, beat_pulse fires, and beats_left decrements. When beats_left reaches 0:
    - If rom_addr = LAST_ADDR: go to end handling.
    - Otherwise rom_addr += 1 and → FETCH.
  - End handling: if loop_en = 1, set rom_addr = 0 and → FETCH. Otherwise pulse done and → IDLE.
- Tone generator:
  - Counter runs 0..half_period; sq toggles on wrap, so the period is 2·(half_period+1) cycles.
  - Counter and sq hold while tone_en = 0.
- tone_en = (state == PLAY) && half_period ≠ 0 && !pause && !(last beat && beat_cnt ≥ BEAT_CYCLES − GAP_CYCLES).
- Priority when inputs coincide: resetn > stop > start > pause.
  - start during FETCH, LOAD, or PLAY restarts from address 0 (→ FETCH).
  - pause is ignored outside PLAY.
  - stop in IDLE has no effect.
- Reset values: rom_addr 0, half_period 0, tone_en 0, sample 0, playing 0, beat_pulse 0, done 0; state IDLE.

## Timing
- start sampled at cycle t:
  - FETCH at t+1 with rom_addr = 0.
  - LOAD at t+2.
  - PLAY at t+3; tone_en is high from t+3 if the note is not a rest.
- A note of d beats occupies d·BEAT_CYCLES cycles in PLAY, plus 2 cycles (FETCH, LOAD) before the next note. The output is silent during those 2 cycles.
- pause for p cycles extends the current note by exactly p cycles. The tone phase resumes where it stopped.
- stop at cycle t: IDLE, tone_en = 0, and sample = 0 at t+1.
- done is asserted in the cycle the FSM enters IDLE from end handling.
- beat_pulse and the final-beat transition occur in the same cycle.

## Structure
- Shared package melody_pkg holds:
  - the state enum
  - duration code constants and a beats-decode function
  - ROM field positions: HP_LSB/MSB, DUR_LSB/MSB
  - the END_CODE constant
- One sub-module, tone_gen: half-period counter plus the sq flip-flop. Inputs: en, clr, half_period. Output: sq.
- The sequencer FSM, beat counter, and sample mux live in melody_sequencer.

## Test plan
Use BEAT_CYCLES = 20, GAP_CYCLES = 4, LAST_ADDR = 3, and a behavioral ROM model with 1-cycle latency.
- Reset: resetn low mid-PLAY → all outputs 0 and state IDLE asynchronously; no done pulse.
- Single note: ROM[0] = {01, 18'd3} → rom_addr 0 at t+1, PLAY at t+3, sq period 8 cycles, tone_en high for 36 cycles then low for 4, rom_addr = 1 at t+43.
- Rest and end marker: ROM[1] = {00, 0}, ROM[2] = {11, x} → 20 cycles of sample 0, then done pulses once and playing = 0.
- LAST_ADDR wrap with loop_en = 1: after ROM[3] completes, rom_addr returns to 0, no done pulse, playback continues.
- Pause: pause high for 10 cycles mid-note → note ends 10 cycles later; sample = 0 while paused; sq phase is continuous across the pause.
- Collision: start and stop in the same cycle during PLAY → IDLE (stop wins). Then start alone → restart at rom_addr 0.
